dmem_bus_ctrl: RTL and testbench



---
 rtl/dmem_bus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - data-side bus master: handshaked load/store cycles, lane steering, load extension
// Optional macro DBUS_TIMEOUT_EN: bus error when ACKD_n stays high for TIMEOUT_CYCLES cycles in BUS.
module dmem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [1:0]       r_size;
  logic             r_write;
  logic             r_signed;
  logic             r_mis;
  logic             r_to;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mis_req;
  logic             w_ack;
  logic             w_timeout;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_ext;
  logic [31:0]      w_lane_wdata;

  // Size 2'b11 is treated as a word everywhere.
  assign w_mis_req = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
  assign w_ack     = ~ACKD_n;

`ifdef DBUS_TIMEOUT_EN
  assign w_timeout = ~w_ack && (32'(r_cnt) >= 32'(TIMEOUT_CYCLES - 1));
  assign bus_err   = (r_state == S_DONE) && r_to;
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign bus_err          = 1'b0;
  assign w_unused_timeout = &{1'b0, r_cnt, r_to, (TIMEOUT_CYCLES != 0)};
`endif

  always_comb begin
    w_byte = DDT[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? DDT[31:16] : DDT[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_ext = DDT;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_lane_wdata = {4{r_wdata[7:0]}};
      2'b01:   w_lane_wdata = {2{r_wdata[15:0]}};
      default: w_lane_wdata = r_wdata;
    endcase
  end

  assign DDT   = ((r_state == S_BUS) && r_write) ? w_lane_wdata : 32'bz;
  assign rdata = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A request in IDLE stalls immediately; reset overrides it so the pipeline is released at once.
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    MREQ        = 1'b0;
    WRITE       = 1'b0;
    SIZE        = 2'b00;
    DAD         = 32'h0;
    rdata_valid = 1'b0;
    misalign    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          stall  = ~rst;
          w_next = w_mis_req ? S_DONE : S_BUS;
        end
      end
      S_BUS: begin
        stall = 1'b1;
        MREQ  = 1'b1;
        WRITE = r_write;
        SIZE  = r_size;
        DAD   = {r_addr[31:2], 2'b00};
        if (w_ack || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        rdata_valid = ~r_write;
        misalign    = r_mis;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_size   <= 2'b00;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_mis    <= 1'b0;
      r_to     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_write  <= req_write;
            r_signed <= req_signed;
            r_mis    <= w_mis_req;
            r_to     <= 1'b0;
            r_cnt    <= '0;
            if (w_mis_req && !req_write) begin
              r_rdata <= 32'h0;
            end
          end
        end
        S_BUS: begin
          if (w_ack) begin
            if (!r_write) begin
              r_rdata <= w_load_ext;
            end
          end else if (w_timeout) begin
            r_to <= 1'b1;
            if (!r_write) begin
              r_rdata <= 32'h0;
            end
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - directed bench with a per-cycle expectation model for dmem_bus_ctrl
module tb_dmem_bus_ctrl;

  localparam int TO = 4;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        ACKD_n = 1'b1;
  logic        stall, rdata_valid, misalign, bus_err, MREQ, WRITE;
  logic [31:0] rdata, DAD;
  logic [1:0]  SIZE;
  wire  [31:0] DDT;
  logic        tb_rel = 1'b0;
  logic [31:0] tb_ddt = 32'h0;

  assign DDT = tb_rel ? 32'bz : tb_ddt;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign(misalign), .bus_err(bus_err), .DAD(DAD), .DDT(DDT), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, mreq, wr, rv, mis, berr;
    logic [1:0]  size;
    logic [31:0] dad, ddt, rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a, wd;
    int          waits;
    logic [31:0] bus;
    logic        drop;
    logic [31:0] x_rdata;
    int          x_stall, x_mreq;
    logic [31:0] x_ddt;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        cur;
  vec_t        vecs[13];
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_cnt = 0, mreq_cnt = 0, mis_cnt = 0, berr_cnt = 0;
  logic [31:0] last_ddt = 32'h0;
  logic [31:0] model_rdata = 32'h0;
  int          d_stall, d_mreq, d_mis, d_berr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {4{wd[7:0]}};
    if (sz == 2'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (d >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic exp_t mk(input logic st, input logic mq, input logic w, input logic [1:0] sz,
                              input logic [31:0] dad, input logic [31:0] dd,
                              input logic rv, input logic mi, input logic be);
    exp_t e;
    e.stall = st; e.mreq = mq; e.wr = w; e.size = sz; e.dad = dad; e.ddt = dd;
    e.rv = rv; e.mis = mi; e.berr = be; e.rdata = model_rdata;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      stall_cnt += int'(stall);
      mreq_cnt  += int'(MREQ);
      mis_cnt   += int'(misalign);
      berr_cnt  += int'(bus_err);
      if (MREQ) last_ddt = DDT;
      check("stall", 32'(stall), 32'(cur.stall));
      check("MREQ", 32'(MREQ), 32'(cur.mreq));
      check("WRITE", 32'(WRITE), 32'(cur.wr));
      check("rdata_valid", 32'(rdata_valid), 32'(cur.rv));
      check("misalign", 32'(misalign), 32'(cur.mis));
      check("bus_err", 32'(bus_err), 32'(cur.berr));
      check("rdata", rdata, cur.rdata);
      check("DDT", DDT, cur.ddt);
      if (cur.mreq) begin
        check("SIZE", 32'(SIZE), 32'(cur.size));
        check("DAD", DAD, cur.dad);
      end
    end
  end

  // One request: IDLE cycle, BUS cycles (none if misaligned), DONE, then an idle cycle.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, input int waits, input logic [31:0] bus, input logic drop);
    int  s0, m0, i0, b0, nbus;
    bit  mis, to;
    s0 = stall_cnt; m0 = mreq_cnt; i0 = mis_cnt; b0 = berr_cnt;
    mis  = is_mis(sz, a);
    to   = !mis && TO_EN && (waits >= TO);
    nbus = mis ? 0 : (to ? TO : waits + 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; ACKD_n = 1'b0; tb_rel = 1'b0; tb_ddt = 32'h0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, sz, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < nbus; i++) begin
      @(posedge clk); #1;
      ACKD_n = (i < waits);
      tb_rel = wr;
      tb_ddt = wr ? 32'h0 : bus;
      if (drop) begin
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_size = ~sz; req_write = ~wr;
      end
      exp_q.push_back(mk(1'b1, 1'b1, wr, sz, {a[31:2], 2'b00},
                         wr ? store_lanes(sz, wd) : bus, 1'b0, 1'b0, 1'b0));
    end
    if (!wr) model_rdata = (mis || to) ? 32'h0 : load_ext(sz, sg, a, bus);
    @(posedge clk); #1;
    ACKD_n = 1'b0; tb_rel = 1'b0; tb_ddt = 32'h0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, sz, 32'h0, 32'h0, !wr, mis, to));
    @(posedge clk); #1;
    req_valid = 1'b0; ACKD_n = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, sz, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); #1;
    d_stall = stall_cnt - s0; d_mreq = mreq_cnt - m0; d_mis = mis_cnt - i0; d_berr = berr_cnt - b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        3, 32'h80000000, 1'b1, 32'hFFFFFF80, 5, 4, 32'h80000000};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        3, 32'h80000000, 1'b0, 32'h00000080, 5, 4, 32'h80000000};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h1234ABCD, 1, 32'h0,        1'b0, 32'h00000080, 3, 2, 32'hABCDABCD};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        0, 32'h0,        1'b0, 32'h00000000, 1, 0, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h2,   32'h0,        0, 32'h80011234, 1'b0, 32'hFFFF8001, 2, 1, 32'h80011234};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h4,   32'h0,        2, 32'h80011234, 1'b0, 32'h00001234, 4, 3, 32'h80011234};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h9,   32'h0,        1, 32'h0000A500, 1'b0, 32'hFFFFFFA5, 3, 2, 32'h0000A500};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h41,  32'h7788995A, 0, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 1, 32'h5A5A5A5A};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h31,  32'h11112222, 0, 32'h0,        1'b0, 32'hFFFFFFA5, 1, 0, 32'h0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h80,  32'hCAFEF00D, 0, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 1, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h44,  32'h0,        0, 32'h01234567, 1'b1, 32'h01234567, 2, 1, 32'h01234567};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h1,   32'h0,        0, 32'h0,        1'b0, 32'h00000000, 1, 0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_MREQ", 32'(MREQ), 32'h0);
    check("rst_WRITE", 32'(WRITE), 32'h0);
    check("rst_SIZE", 32'(SIZE), 32'h0);
    check("rst_DAD", DAD, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulses", {29'h0, rdata_valid, misalign, bus_err}, 32'h0);
    check("rst_DDT", DDT, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      txn(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].a, vecs[v].wd,
          vecs[v].waits, vecs[v].bus, vecs[v].drop);
      check($sformatf("v%0d_rdata", v), rdata, vecs[v].x_rdata);
      check($sformatf("v%0d_stall_cycles", v), 32'(d_stall), 32'(vecs[v].x_stall));
      check($sformatf("v%0d_mreq_cycles", v), 32'(d_mreq), 32'(vecs[v].x_mreq));
      check($sformatf("v%0d_misalign_pulses", v), 32'(d_mis), (vecs[v].x_mreq == 0) ? 32'd1 : 32'd0);
      if (vecs[v].x_mreq != 0) check($sformatf("v%0d_bus_ddt", v), last_ddt, vecs[v].x_ddt);
    end

    txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 100, 32'h11111111, 1'b0);
`ifdef DBUS_TIMEOUT_EN
    check("to_mreq_cycles", 32'(d_mreq), 32'd4);
    check("to_bus_err_pulses", 32'(d_berr), 32'd1);
    check("to_rdata", rdata, 32'h0);
`else
    check("noto_mreq_cycles", 32'(d_mreq), 32'd101);
    check("noto_bus_err_pulses", 32'(d_berr), 32'd0);
    check("noto_rdata", rdata, 32'h11111111);
`endif

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h200; req_wdata = 32'hCAFEF00D; ACKD_n = 1'b1;
    @(posedge clk); #1;
    tb_rel = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_MREQ", 32'(MREQ), 32'h1);
    #1;
    rst = 1'b1; tb_rel = 1'b0; tb_ddt = 32'h0;
    #1;
    check("async_rst_MREQ", 32'(MREQ), 32'h0);
    check("async_rst_stall", 32'(stall), 32'h0);
    check("async_rst_DDT", DDT, 32'h0);
    check("async_rst_pulses", {29'h0, rdata_valid, misalign, bus_err}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    model_rdata = 32'h0;
    check("post_rst_rdata", rdata, 32'h0);

    txn(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    check("post_rst_sw_ddt", last_ddt, 32'hCAFEF00D);
    txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, 32'h0BADF00D, 1'b0);
    check("post_rst_lw_rdata", rdata, 32'h0BADF00D);
    check("post_rst_lw_stall", 32'(d_stall), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
